// File: rtl/i2c_tx_feeder.sv
// i2c_tx_feeder: FIFO of (addr, data) write requests launched one at a time into the I2C transmitter.
// Optional launch timeout is compiled in with `define I2C_FEED_TIMEOUT_EN.
module i2c_tx_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    i2c_clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [6:0]              push_addr,
    input  logic [7:0]              push_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    tx_ready,
    output logic                    tx_start,
    output logic [6:0]              tx_addr,
    output logic [7:0]              tx_data,
    output logic [15:0]             sent_count,
    output logic                    err_timeout,
    output logic [1:0]              fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("i2c_tx_feeder: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
    end

    state_t        state;
    state_t        state_next;
    logic [14:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push_ok;
    logic          pop;
    logic          done;

    // Handshake: tx_start is held in LAUNCH until the transmitter leaves IDLE (tx_ready low),
    // and the transfer is complete when tx_ready returns high in WAIT_DONE.
    assign push_ok   = push && !full;
    assign level     = count;
    assign fsm_state = state;

`ifdef I2C_FEED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] launch_cnt;
    logic          timeout_hit;
    logic          timeout_fire;

    assign timeout_hit  = (launch_cnt == TW'(TIMEOUT - 1));
    assign timeout_fire = (state == LAUNCH) && tx_ready && timeout_hit;

    // Counter sits at zero outside LAUNCH, so it is clear on every entry.
    always_ff @(posedge i2c_clk) begin
        if (reset || state != LAUNCH) begin
            launch_cnt <= '0;
        end else begin
            launch_cnt <= launch_cnt + 1'b1;
        end
    end

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else if (timeout_fire) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i2c_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full) overflow <= 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_LEVEL);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!empty && tx_ready) state_next = LAUNCH;
            LAUNCH: begin
                if (!tx_ready) state_next = WAIT_DONE;
`ifdef I2C_FEED_TIMEOUT_EN
                else if (timeout_hit) state_next = IDLE;
`endif
            end
            WAIT_DONE: if (tx_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == IDLE) && !empty && tx_ready;
        tx_start = (state == LAUNCH);
        done     = (state == WAIT_DONE) && tx_ready;
    end

    // Launched request is latched at pop and held until the next pop.
    always_ff @(posedge i2c_clk) begin
        if (reset) begin
            tx_addr    <= '0;
            tx_data    <= '0;
            sent_count <= '0;
        end else begin
            if (pop) begin
                tx_addr <= mem[rd_ptr][14:8];
                tx_data <= mem[rd_ptr][7:0];
            end
            if (done) sent_count <= sent_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_tx_feeder.sv
// Self-checking bench for i2c_tx_feeder: queue-based reference model, launch monitor and model transmitter.
module tb_i2c_tx_feeder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          i2c_clk;
    logic          reset;
    logic          push;
    logic [6:0]    push_addr;
    logic [7:0]    push_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_ready;
    logic          tx_start;
    logic [6:0]    tx_addr;
    logic [7:0]    tx_data;
    logic [15:0]   sent_count;
    logic          err_timeout;
    logic [1:0]    fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q[$];
    int          xmit_mode = 0;   // 0: hold low, 1: hold high, 2: behave as a transmitter
    int          busy_len = 20;
    int          busy_cnt = 0;
    logic        mon_prev = 1'b0;
    logic [14:0] mon_cur = '0;
    int          model_level;
    int          total_sent;

    i2c_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i2c_clk(i2c_clk), .reset(reset), .push(push), .push_addr(push_addr),
        .push_data(push_data), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .tx_ready(tx_ready), .tx_start(tx_start),
        .tx_addr(tx_addr), .tx_data(tx_data), .sent_count(sent_count),
        .err_timeout(err_timeout), .fsm_state(fsm_state)
    );

    initial begin
        i2c_clk = 1'b0;
        forever #5 i2c_clk = ~i2c_clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model transmitter: in mode 2 it leaves IDLE one cycle after seeing tx_start, stays busy busy_len cycles.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge i2c_clk);
            if (xmit_mode == 0) begin
                tx_ready = 1'b0;
                busy_cnt = 0;
            end else if (xmit_mode == 1) begin
                tx_ready = 1'b1;
                busy_cnt = 0;
            end else if (busy_cnt != 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_ready = 1'b1;
            end else if (!tx_ready) begin
                tx_ready = 1'b1;
            end else if (tx_start) begin
                tx_ready = 1'b0;
                busy_cnt = busy_len;
            end
        end
    end

    // Monitor: every tx_start rise must present the oldest accepted request, held while tx_start is high.
    initial begin
        forever begin
            @(negedge i2c_clk);
            if (reset) begin
                mon_prev = 1'b0;
            end else begin
                if (tx_start && !mon_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL launch_unexpected: got addr 0x%0h data 0x%0h, expected no launch",
                                 tx_addr, tx_data);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        check("launch_addr", 32'(tx_addr), 32'(mon_cur[14:8]));
                        check("launch_data", 32'(tx_data), 32'(mon_cur[7:0]));
                    end
                end else if (tx_start) begin
                    check("launch_hold", 32'({tx_addr, tx_data}), 32'(mon_cur));
                end
                mon_prev = tx_start;
            end
        end
    end

    task automatic apply_reset();
        @(negedge i2c_clk);
        reset = 1'b1;
        push = 1'b0;
        xmit_mode = 0;
        exp_q.delete();
        repeat (2) @(negedge i2c_clk);
        reset = 1'b0;
    endtask

    task automatic do_push(input logic [6:0] a, input logic [7:0] d, input bit accept);
        @(negedge i2c_clk);
        push = 1'b1;
        push_addr = a;
        push_data = d;
        if (accept) exp_q.push_back({a, d});
        @(posedge i2c_clk);
        #1;
        push = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fsm_state != 2'd0) && n < budget) begin
            @(negedge i2c_clk);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_addr"}, 32'(tx_addr), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_sent_count"}, 32'(sent_count), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b0;
        push_addr = '0;
        push_data = '0;

        // Reset state
        apply_reset();
        @(negedge i2c_clk);
        check_reset_values("rst");

        // First transfer: latency and completion
        xmit_mode = 1;
        repeat (2) @(negedge i2c_clk);
        do_push(7'h3F, 8'h41, 1'b1);
        @(negedge i2c_clk);
        check("first_empty", 32'(empty), 32'd0);
        check("first_level", 32'(level), 32'd1);
        check("first_start_early", 32'(tx_start), 32'd0);
        busy_len = 20;
        xmit_mode = 2;
        @(negedge i2c_clk);
        check("first_start", 32'(tx_start), 32'd1);
        check("first_addr", 32'(tx_addr), 32'h3F);
        check("first_data", 32'(tx_data), 32'h41);
        wait_drained("first_drain", 60);
        check("first_sent", 32'(sent_count), 32'd1);
        check("first_start_clear", 32'(tx_start), 32'd0);
        check("first_idle", 32'(fsm_state), 32'd0);
        total_sent = 1;

        // Overfill with transmitter busy, then drain in order
        xmit_mode = 0;
        repeat (2) @(negedge i2c_clk);
        model_level = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            bit acc;
            acc = (model_level < DEPTH);
            do_push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), acc);
            if (acc) model_level++;
        end
        @(negedge i2c_clk);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level", 32'(level), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_no_start", 32'(tx_start), 32'd0);
        busy_len = $urandom_range(1, 6);
        xmit_mode = 2;
        wait_drained("ovf_drain", 400);
        total_sent += DEPTH;
        check("ovf_sent", 32'(sent_count), 32'(total_sent));
        check("ovf_empty", 32'(empty), 32'd1);

        // Push while full, coincident with a pop: push dropped
        apply_reset();
        model_level = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1);
            model_level++;
        end
        @(posedge i2c_clk);
        xmit_mode = 1;
        @(negedge i2c_clk);
        check("pp_full_before", 32'(full), 32'd1);
        push = 1'b1;
        push_addr = 7'($urandom_range(0, 127));
        push_data = 8'($urandom_range(0, 255));
        @(posedge i2c_clk);
        #1;
        push = 1'b0;
        busy_len = 3;
        xmit_mode = 2;
        @(negedge i2c_clk);
        check("pp_level", 32'(level), 32'(DEPTH - 1));
        check("pp_overflow", 32'(overflow), 32'd1);
        check("pp_full", 32'(full), 32'd0);
        check("pp_start", 32'(tx_start), 32'd1);
        wait_drained("pp_drain", 200);
        check("pp_sent", 32'(sent_count), 32'(DEPTH));

        // Random bursts against the model transmitter
        apply_reset();
        total_sent = 0;
        xmit_mode = 2;
        for (int b = 0; b < 8; b++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            busy_len = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                do_push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1);
                repeat ($urandom_range(0, 3)) @(negedge i2c_clk);
            end
            wait_drained("rand_drain", 300);
            total_sent += n;
            check("rand_sent", 32'(sent_count), 32'(total_sent));
        end
        check("rand_overflow", 32'(overflow), 32'd0);

        // Reset while in WAIT_DONE with two entries queued
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1);
        end
        busy_len = 20;
        xmit_mode = 2;
        begin
            int n;
            n = 0;
            while (fsm_state != 2'd2 && n < 30) begin
                @(negedge i2c_clk);
                n++;
            end
            check("mid_reach_wait", 32'(n < 30), 32'd1);
        end
        check("mid_queued", 32'(level), 32'd2);
        reset = 1'b1;
        exp_q.delete();
        xmit_mode = 0;
        @(negedge i2c_clk);
        check_reset_values("mid");
        reset = 1'b0;
        repeat (3) @(negedge i2c_clk);
        xmit_mode = 1;
        repeat (6) @(negedge i2c_clk);
        check("mid_after_start", 32'(tx_start), 32'd0);
        check("mid_after_sent", 32'(sent_count), 32'd0);
        check("mid_after_empty", 32'(empty), 32'd1);

`ifdef I2C_FEED_TIMEOUT_EN
        // Launch timeout with tx_ready stuck high
        apply_reset();
        xmit_mode = 1;
        repeat (2) @(negedge i2c_clk);
        do_push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1);
        begin
            int n;
            int high;
            n = 0;
            while (!tx_start && n < 5) begin
                @(negedge i2c_clk);
                n++;
            end
            high = 0;
            while (tx_start && high < 200) begin
                high++;
                @(negedge i2c_clk);
            end
            check("to_high_cycles", 32'(high), 32'(TIMEOUT));
        end
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_sent", 32'(sent_count), 32'd0);
        check("to_empty", 32'(empty), 32'd1);
        check("to_idle", 32'(fsm_state), 32'd0);
`else
        check("no_timeout_err", 32'(err_timeout), 32'd0);
`endif

        repeat (2) @(negedge i2c_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_tx_feeder.md
# i2c_tx_feeder

Upstream command stage for the I2C write transmitter. Host logic pushes (7-bit address, data byte) write requests into a small FIFO. The feeder launches one request at a time into the transmitter via a start/ready handshake and tracks completion. It replaces the transmitter's fixed address/data constants with a queued, host-driven stream.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- TIMEOUT, 64: i2c_clk cycles allowed for the transmitter to accept a start (only with the timeout feature).

Ports:
- i2c_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- push  in  1  write-request strobe, sampled each cycle.
- push_addr  in  7  target slave address.
- push_data  in  8  data byte.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: a push arrived while full.
- tx_ready  in  1  transmitter idle (high only in its IDLE state).
- tx_start  out  1  request launch; held until accepted.
- tx_addr  out  7  address of the launched request; stable from tx_start rise until the feeder returns to IDLE.
- tx_data  out  8  data byte of the launched request; same stability rule as tx_addr.
- sent_count  out  16  completed transfers; wraps at 0xFFFF->0.
- err_timeout  out  1  sticky launch-timeout flag.

## Operation
- FIFO: DEPTH x 15 bits {addr, data}, with wrapping read and write pointers plus a separate count.
- A push is accepted iff full==0 at that edge.
- A push while full is dropped and sets overflow. The FIFO and pointers are unchanged.
- Pop happens only on the IDLE->LAUNCH transition.
- Push and pop in the same cycle: both happen and level is unchanged. A push is still rejected if full was 1 at that edge, even with a simultaneous pop.
- FSM states:
  - IDLE: if empty==0 and tx_ready==1, pop the head into tx_addr/tx_data, set tx_start=1 and go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_start=1. When tx_ready==0 is sampled, set tx_start=0 and go to WAIT_DONE.
  - WAIT_DONE: when tx_ready==1 is sampled, increment sent_count and go to IDLE.
- Back-to-back entries: the next launch is evaluated in the cycle after IDLE is re-entered.
- Reset mid-transfer: the FSM goes to IDLE and the FIFO is emptied. The in-flight request is abandoned and not counted.

## Timing
- Reset values: full=0, empty=1, level=0, overflow=0, tx_start=0, tx_addr=0, tx_data=0, sent_count=0, err_timeout=0. FSM state is IDLE.
- Flags and level are registered. They reflect a push or pop one cycle after the edge that performed it.
- Push-to-launch latency with tx_ready held high:
  - push sampled at edge N,
  - empty=0 after edge N,
  - tx_start=1 after edge N+1 (2 cycles).
- tx_start falls on the edge after tx_ready is first sampled low.
- Minimum transfer occupancy is 3 cycles (IDLE, LAUNCH, WAIT_DONE), plus the transmitter's own busy time.

## Configuration
- I2C_FEED_TIMEOUT_EN defined:
  - LAUNCH has a counter that clears on entry.
  - If TIMEOUT cycles pass without tx_ready low: set tx_start=0, set err_timeout (sticky until reset), discard the entry without counting it, and return to IDLE.
- Macro undefined:
  - LAUNCH waits indefinitely.
  - err_timeout is constant 0.
  - No counter logic is generated.

## Test plan
- Reset, then push (0x3F, 0x41) with tx_ready=1: empty falls one cycle later; tx_start=1 two cycles after the push with tx_addr=0x3F, tx_data=0x41.
- Model transmitter: drop tx_ready one cycle after tx_start, busy 20 cycles, then raise it. Expect tx_start to clear, sent_count=1 after tx_ready rises, and the FSM back in IDLE.
- Push DEPTH+1 entries with tx_ready=0: full=1, level=DEPTH, overflow=1. Drain with the model transmitter: exactly DEPTH transfers in push order, and sent_count=DEPTH.
- With full=1 in IDLE, assert push together with tx_ready=1 (pop): the push is dropped, overflow is set, and level becomes DEPTH-1.
- Assert reset while in WAIT_DONE with 2 entries queued: next cycle all outputs hold their reset values and sent_count=0.
- With I2C_FEED_TIMEOUT_EN defined and TIMEOUT=64, push one entry and hold tx_ready=1 constantly. Expect tx_start high for 64 cycles then low, err_timeout=1, sent_count=0, and empty=1.
